// File: rtl/apa102_frame_receiver_if.sv
// apa102_frame_receiver_if
//   Bundles the APA102-style SPI link (sclk/mosi) with the decoded LED outputs
//   of apa102_frame_receiver.
//   master : drives sclk/mosi, observes the decoded fields (strip driver / bench)
//   slave  : receives sclk/mosi, drives the decoded fields (the receiver)
//   Signals: sclk, mosi, led_valid, led_index[IDX_W], led_brightness[5],
//            led_r/led_g/led_b[8], frame_done, frame_error
interface apa102_frame_receiver_if #(
  parameter int IDX_W = 3
);
  logic             sclk;
  logic             mosi;
  logic             led_valid;
  logic [IDX_W-1:0] led_index;
  logic [4:0]       led_brightness;
  logic [7:0]       led_r;
  logic [7:0]       led_g;
  logic [7:0]       led_b;
  logic             frame_done;
  logic             frame_error;

  modport master (
    output sclk, mosi,
    input  led_valid, led_index, led_brightness, led_r, led_g, led_b,
           frame_done, frame_error
  );

  modport slave (
    input  sclk, mosi,
    output led_valid, led_index, led_brightness, led_r, led_g, led_b,
           frame_done, frame_error
  );
endinterface

// File: rtl/apa102_frame_receiver.sv
// apa102_frame_receiver
//   Receiving end of an APA102-style SPI strip link, running in the sys_clk
//   domain. sclk/mosi are oversampled through synchroniser chains, the 32-bit
//   zero start frame is located, and NUM_LEDS LED frames are decoded, each
//   producing a one-cycle led_valid strobe with its fields.
// Ports
//   sys_clk : system clock
//   rst     : synchronous active-high reset
//   bus     : apa102_frame_receiver_if.slave (sclk/mosi in, decoded LED
//             fields, frame_done and frame_error strobes out)
// Build option
//   APA102_RX_TIMEOUT_EN : when defined, a frame stalled in the LED state for
//   TIMEOUT_CLKS cycles without an sclk rise is aborted with frame_error.
module apa102_frame_receiver #(
  parameter int NUM_LEDS    = 8,
  parameter int IDX_W       = 3,
  parameter int SYNC_STAGES = 2
`ifdef APA102_RX_TIMEOUT_EN
  , parameter int TIMEOUT_CLKS = 100000
`endif
) (
  input  logic                   sys_clk,
  input  logic                   rst,
  apa102_frame_receiver_if.slave bus
);

  typedef enum logic [1:0] {HUNT, LED, TRAIL} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LEDS - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync;
  logic                   sclk_d;
  logic [31:0]            sr;
  logic [5:0]             zero_run;
  logic [4:0]             bit_cnt;
  logic [IDX_W-1:0]       idx;
  logic                   word_pend;   // 32nd bit just shifted in; decode next cycle

  logic                   rise;
  logic                   bit_in;
  logic [5:0]             zero_nxt;

`ifdef APA102_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  assign rise     = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
  assign bit_in   = mosi_sync[SYNC_STAGES-1];
  assign zero_nxt = bit_in ? 6'd0 : (zero_run == 6'd32) ? 6'd32 : zero_run + 6'd1;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state              <= HUNT;
      sclk_sync          <= '0;
      mosi_sync          <= '0;
      sclk_d             <= 1'b0;
      sr                 <= '0;
      zero_run           <= '0;
      bit_cnt            <= '0;
      idx                <= '0;
      word_pend          <= 1'b0;
      bus.led_valid      <= 1'b0;
      bus.led_index      <= '0;
      bus.led_brightness <= '0;
      bus.led_r          <= '0;
      bus.led_g          <= '0;
      bus.led_b          <= '0;
      bus.frame_done     <= 1'b0;
      bus.frame_error    <= 1'b0;
`ifdef APA102_RX_TIMEOUT_EN
      to_cnt             <= '0;
`endif
    end else begin
      sclk_sync       <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync       <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      sclk_d          <= sclk_sync[SYNC_STAGES-1];
      bus.led_valid   <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_error <= 1'b0;

      // sclk high/low last >= 3 cycles, so no rise can land in the decode cycle
      if (word_pend) begin
        word_pend <= 1'b0;
`ifdef APA102_RX_TIMEOUT_EN
        to_cnt    <= '0;
`endif
        if (sr[31:29] == 3'b111) begin
          bus.led_valid      <= 1'b1;
          bus.led_index      <= idx;
          bus.led_brightness <= sr[28:24];
          bus.led_b          <= sr[23:16];
          bus.led_g          <= sr[15:8];
          bus.led_r          <= sr[7:0];
          if (idx == LAST_IDX) begin
            bus.frame_done <= 1'b1;
            state          <= TRAIL;
            idx            <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end else begin
          // zero_run is left alone so a start frame already in progress still counts
          bus.frame_error <= 1'b1;
          state           <= HUNT;
          idx             <= '0;
        end
      end else if (rise) begin
        sr       <= {sr[30:0], bit_in};
        zero_run <= zero_nxt;
`ifdef APA102_RX_TIMEOUT_EN
        to_cnt   <= '0;
`endif
        case (state)
          HUNT, TRAIL: begin
            if (zero_nxt == 6'd32) begin
              state   <= LED;
              bit_cnt <= '0;
              idx     <= '0;
            end
          end
          LED: begin
            // surplus start-frame zeros ahead of the first LED word are swallowed
            if (!(idx == '0 && bit_cnt == '0 && !bit_in)) begin
              bit_cnt <= bit_cnt + 1'b1;   // wraps to 0 after the 32nd bit
              if (bit_cnt == 5'd31) word_pend <= 1'b1;
            end
          end
          default: state <= HUNT;
        endcase
      end
`ifdef APA102_RX_TIMEOUT_EN
      else if (state == LED) begin
        if (to_cnt == TO_W'(TIMEOUT_CLKS - 1)) begin
          bus.frame_error <= 1'b1;
          state           <= HUNT;
          bit_cnt         <= '0;
          idx             <= '0;
          zero_run        <= '0;
          to_cnt          <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_apa102_frame_receiver.sv
// tb_apa102_frame_receiver
//   Directed sequence with randomised LED words for apa102_frame_receiver.
//   Expected LED events are derived from the words sent; a monitor collects
//   what the receiver reports.
module tb_apa102_frame_receiver;
  localparam int NL = 8;
  localparam int IW = 3;
  localparam int SS = 2;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;

  apa102_frame_receiver_if #(.IDX_W(IW)) bus ();

`ifdef APA102_RX_TIMEOUT_EN
  apa102_frame_receiver #(.NUM_LEDS(NL), .IDX_W(IW), .SYNC_STAGES(SS), .TIMEOUT_CLKS(1000))
    dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));
`else
  apa102_frame_receiver #(.NUM_LEDS(NL), .IDX_W(IW), .SYNC_STAGES(SS))
    dut (.sys_clk(sys_clk), .rst(rst), .bus(bus));
`endif

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // observed events: {idx, 3'b0, brightness, b, g, r}
  logic [39:0] got_q[$];
  int          lat_q[$];
  logic [39:0] exp_q[$];
  int n_done = 0, n_err = 0, n_badcoinc = 0;

  always @(negedge sys_clk) begin
    if (!rst) begin
      if (bus.led_valid) begin
        got_q.push_back({8'(bus.led_index), 3'b000, bus.led_brightness, bus.led_b, bus.led_g, bus.led_r});
        lat_q.push_back(cyc - rise_cyc);
      end
      if (bus.frame_done) begin
        n_done++;
        if (!(bus.led_valid && bus.led_index == IW'(NL - 1))) n_badcoinc++;
      end
      if (bus.frame_error) begin
        n_err++;
        if (bus.led_valid) n_badcoinc++;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge sys_clk);
    bus.mosi = b;
    repeat (4) @(negedge sys_clk);
    bus.sclk = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge sys_clk);
    bus.sclk = 1'b0;
  endtask

  task automatic send_const(input logic b, input int n);
    for (int i = 0; i < n; i++) send_bit(b);
  endtask

  task automatic send_bits(input logic [31:0] w, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(w[i]);
  endtask

  function automatic logic [31:0] rand_word();
    return {3'b111, 5'($urandom), 24'($urandom)};
  endfunction

  // what one decoded LED word should look like on the outputs
  function automatic logic [39:0] led_ev(input int i, input logic [31:0] w);
    logic [4:0] br;
    logic [7:0] b, g, r;
    br = 5'((w >> 24) % 32);
    b  = 8'((w >> 16) % 256);
    g  = 8'((w >> 8) % 256);
    r  = 8'(w % 256);
    return {8'(i), 3'b000, br, b, g, r};
  endfunction

  task automatic expect_leds(input logic [31:0] w[NL], input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(led_ev(i, w[i]));
  endtask

  task automatic settle();
    repeat (10) @(negedge sys_clk);
  endtask

  task automatic check_events(input string tag, input int exp_done, input int exp_err);
    int n;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_led%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    chk({tag, "_done"}, 64'(n_done), 64'(exp_done));
    chk({tag, "_err"},  64'(n_err),  64'(exp_err));
    got_q.delete(); lat_q.delete(); exp_q.delete();
    n_done = 0; n_err = 0;
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, 64'({bus.led_valid, bus.led_index, bus.led_brightness, bus.led_r, bus.led_g,
                  bus.led_b, bus.frame_done, bus.frame_error}), 64'd0);
  endtask

  initial begin
    logic [31:0] w[NL];
    logic [31:0] w2[NL];
    int waited;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge sys_clk);
    outs_zero("reset_outs");
    rst = 1'b0;
    settle();

    // 1: reference frame of identical words
    for (int i = 0; i < NL; i++) w[i] = 32'hE140_0020;
    send_const(1'b0, 32);
    for (int i = 0; i < NL; i++) send_bits(w[i], 31, 0);
    settle();
    chk("t1_latency", 64'((lat_q.size() > 0) ? lat_q[0] : -1), 64'(SS + 2));
    send_const(1'b1, 32);
    settle();
    expect_leds(w, NL);
    check_events("t1", 1, 0);

    // 2: bad header on LED 2 aborts, the next frame decodes normally
    for (int i = 0; i < NL; i++) w[i] = rand_word();
    w[2] = 32'hC140_0020;
    send_const(1'b0, 32);
    for (int i = 0; i < NL; i++) send_bits(w[i], 31, 0);
    send_const(1'b1, 32);
    settle();
    expect_leds(w, 2);
    check_events("t2a", 0, 1);
    for (int i = 0; i < NL; i++) w[i] = rand_word();
    send_const(1'b0, 32);
    for (int i = 0; i < NL; i++) send_bits(w[i], 31, 0);
    send_const(1'b1, 32);
    settle();
    expect_leds(w, NL);
    check_events("t2b", 1, 0);

    // 3: extra start zeros
    for (int i = 0; i < NL; i++) w[i] = rand_word();
    send_const(1'b0, 40);
    for (int i = 0; i < NL; i++) send_bits(w[i], 31, 0);
    send_const(1'b1, 32);
    settle();
    expect_leds(w, NL);
    check_events("t3", 1, 0);

    // 4: reset in the middle of LED 3
    for (int i = 0; i < NL; i++) w[i] = rand_word();
    send_const(1'b0, 32);
    for (int i = 0; i < 3; i++) send_bits(w[i], 31, 0);
    send_bits(w[3], 31, 16);
    settle();
    expect_leds(w, 3);
    check_events("t4a", 0, 0);
    @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);
    rst = 1'b0;
    outs_zero("t4_rst_outs");
    settle();
    for (int i = 0; i < NL; i++) w[i] = rand_word();
    send_const(1'b0, 32);
    for (int i = 0; i < NL; i++) send_bits(w[i], 31, 0);
    send_const(1'b1, 32);
    settle();
    expect_leds(w, NL);
    check_events("t4b", 1, 0);

    // 5: sclk stalls after 10 bits of LED 4
    for (int i = 0; i < NL; i++) w[i] = rand_word();
    send_const(1'b0, 32);
    for (int i = 0; i < 4; i++) send_bits(w[i], 31, 0);
    send_bits(w[4], 31, 22);
`ifdef APA102_RX_TIMEOUT_EN
    waited = 0;
    while (n_err == 0 && waited < 1500) begin
      @(negedge sys_clk);
      waited++;
    end
    chk("t5_to_seen", 64'(n_err), 64'd1);
    chk("t5_to_delay_ok", 64'((cyc - rise_cyc) >= 1000 && (cyc - rise_cyc) <= 1006), 64'd1);
    settle();
    expect_leds(w, 4);
    check_events("t5a", 0, 1);
    for (int i = 0; i < NL; i++) w[i] = rand_word();
    send_const(1'b0, 32);
    for (int i = 0; i < NL; i++) send_bits(w[i], 31, 0);
    send_const(1'b1, 32);
    settle();
    expect_leds(w, NL);
    check_events("t5b", 1, 0);
`else
    waited = 0;
    while (n_err == 0 && waited < 1200) begin
      @(negedge sys_clk);
      waited++;
    end
    chk("t5_no_err", 64'(n_err), 64'd0);
    send_bits(w[4], 21, 0);
    for (int i = 5; i < NL; i++) send_bits(w[i], 31, 0);
    send_const(1'b1, 32);
    settle();
    expect_leds(w, NL);
    check_events("t5", 1, 0);
`endif

    // 6: two frames back to back without an end frame
    for (int i = 0; i < NL; i++) begin
      w[i]  = rand_word();
      w2[i] = rand_word();
    end
    send_const(1'b0, 32);
    for (int i = 0; i < NL; i++) send_bits(w[i], 31, 0);
    send_const(1'b0, 32);
    for (int i = 0; i < NL; i++) send_bits(w2[i], 31, 0);
    send_const(1'b1, 32);
    settle();
    expect_leds(w, NL);
    expect_leds(w2, NL);
    check_events("t6", 2, 0);

    chk("strobe_coincidence", 64'(n_badcoinc), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case the sequence above never completes
  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
